// File: rtl/reaction_timer_ctrl.sv
// Sequencing controller for the reaction-timer BCD counter: clear, prescaled delay,
// stimulus LED, prescaled count enables, early-press detection and saturation at 99.
module reaction_timer_ctrl #(
    parameter int DIV         = 500,
    parameter int DELAY_TICKS = 8
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Go,
    input  logic       Stop,
    input  logic [3:0] BCD1,
    input  logic [3:0] BCD0,
    output logic       Clear,
    output logic       E,
    output logic       LED,
    output logic       Done,
    output logic       Early,
    output logic       Ovf
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [7:0]    DELAY_LAST = 8'(DELAY_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WAIT,
        S_RUN,
        S_HOLD
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [7:0]      delay_reg, delay_next;
    logic            clear_reg, clear_next;
    logic            e_reg, e_next;
    logic            led_reg, led_next;
    logic            done_reg, done_next;
    logic            early_reg, early_next;
    logic            ovf_reg, ovf_next;

    logic            tick;
    logic            last_delay;
    logic            at_99;
    logic [3:0]      digit [2];
    logic [1:0]      digit_nine;

    assign tick       = (presc_reg == PRESC_LAST);
    assign last_delay = (delay_reg == DELAY_LAST);

    // Saturation triggers only on the exact pattern 9,9; other digit values are trusted.
    assign digit[0] = BCD0;
    assign digit[1] = BCD1;
    for (genvar gi = 0; gi < 2; gi++) begin : g_nine
        assign digit_nine[gi] = (digit[gi] == 4'd9);
    end
    assign at_99 = &digit_nine;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= S_IDLE;
            presc_reg <= '0;
            delay_reg <= '0;
            clear_reg <= 1'b0;
            e_reg     <= 1'b0;
            led_reg   <= 1'b0;
            done_reg  <= 1'b0;
            early_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            delay_reg <= delay_next;
            clear_reg <= clear_next;
            e_reg     <= e_next;
            led_reg   <= led_next;
            done_reg  <= done_next;
            early_reg <= early_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (Go) state_next = S_CLR;
            S_CLR:  state_next = S_WAIT;
            S_WAIT: begin
                if (Stop)                    state_next = S_HOLD;
                else if (tick && last_delay) state_next = S_RUN;
            end
            S_RUN: begin
                if (Stop)               state_next = S_HOLD;
                else if (tick && at_99) state_next = S_HOLD;
            end
            S_HOLD: if (Go) state_next = S_CLR;
            default: state_next = S_IDLE;
        endcase
    end

    // Registered outputs and datapath next values; Clear and E default low so they pulse.
    always_comb begin
        presc_next = presc_reg;
        delay_next = delay_reg;
        clear_next = 1'b0;
        e_next     = 1'b0;
        led_next   = led_reg;
        done_next  = done_reg;
        early_next = early_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            S_IDLE, S_HOLD: begin
                if (Go) begin
                    clear_next = 1'b1;
                    done_next  = 1'b0;
                    early_next = 1'b0;
                    ovf_next   = 1'b0;
                end
            end
            S_CLR: begin
                presc_next = '0;
                delay_next = '0;
                led_next   = 1'b0;
                done_next  = 1'b0;
                early_next = 1'b0;
                ovf_next   = 1'b0;
            end
            S_WAIT: begin
                presc_next = tick ? '0 : presc_reg + PW'(1);
                if (tick) delay_next = delay_reg + 8'd1;
                if (Stop) begin
                    early_next = 1'b1;
                    done_next  = 1'b1;
                end else if (tick && last_delay) begin
                    led_next = 1'b1;
                end
            end
            S_RUN: begin
                presc_next = tick ? '0 : presc_reg + PW'(1);
                if (Stop) begin
                    led_next  = 1'b0;
                    done_next = 1'b1;
                end else if (tick) begin
                    if (at_99) begin
                        ovf_next  = 1'b1;
                        done_next = 1'b1;
                        led_next  = 1'b0;
                    end else begin
                        e_next = 1'b1;
                    end
                end
            end
            default: begin
                led_next = 1'b0;
            end
        endcase
    end

    assign Clear = clear_reg;
    assign E     = e_reg;
    assign LED   = led_reg;
    assign Done  = done_reg;
    assign Early = early_reg;
    assign Ovf   = ovf_reg;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: directed runs plus random Go/Stop traffic, checked every
// cycle against a timing-formula model and a behavioural BCD counter on Clear/E.
module tb_reaction_timer_ctrl;
    localparam int DIV      = 4;
    localparam int DLY      = 3;
    localparam int LED_EDGE = 1 + DLY * DIV;

    localparam int M_IDLE   = 0;
    localparam int M_ACTIVE = 1;
    localparam int M_HOLD   = 2;

    logic       Clock  = 1'b0;
    logic       Resetn = 1'b0;
    logic       Go     = 1'b0;
    logic       Stop   = 1'b0;
    logic [3:0] BCD1, BCD0;
    logic       Clear, E, LED, Done, Early, Ovf;
    logic [7:0] cnt_reg;

    int checks   = 0;
    int failures = 0;

    // Model state: run start edge and edge count, expected outputs, expected count value.
    int   mode;
    int   edge_idx;
    int   n0;
    int   cnt_m;
    logic exp_clear, exp_e, exp_led, exp_done, exp_early, exp_ovf;

    always #5 Clock = ~Clock;

    reaction_timer_ctrl #(.DIV(DIV), .DELAY_TICKS(DLY)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Go     (Go),
        .Stop   (Stop),
        .BCD1   (BCD1),
        .BCD0   (BCD0),
        .Clear  (Clear),
        .E      (E),
        .LED    (LED),
        .Done   (Done),
        .Early  (Early),
        .Ovf    (Ovf)
    );

    // Behavioural two-digit BCD counter driven by Clear and E (wraps 99 -> 00 on its own).
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)                 cnt_reg <= 8'h00;
        else if (Clear)              cnt_reg <= 8'h00;
        else if (E) begin
            if (cnt_reg == 8'h99)        cnt_reg <= 8'h00;
            else if (cnt_reg[3:0] == 4'h9) cnt_reg <= {cnt_reg[7:4] + 4'h1, 4'h0};
            else                         cnt_reg <= cnt_reg + 8'h01;
        end
    end
    assign BCD1 = cnt_reg[7:4];
    assign BCD0 = cnt_reg[3:0];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int c);
        return 32'(((c / 10) << 4) | (c % 10));
    endfunction

    task automatic model_reset();
        mode      = M_IDLE;
        edge_idx  = 0;
        n0        = 0;
        cnt_m     = 0;
        exp_clear = 1'b0;
        exp_e     = 1'b0;
        exp_led   = 1'b0;
        exp_done  = 1'b0;
        exp_early = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    // Expected outputs after one rising edge, from the start edge n0 and the tick arithmetic:
    // ticks at n0+1+j*DIV, LED at tick j=DLY, k-th E pulse at tick DLY+k, saturation at k=100.
    task automatic model_step(input bit go, input bit stop);
        int r;
        int j;
        if (exp_clear)  cnt_m = 0;
        else if (exp_e) cnt_m = (cnt_m == 99) ? 0 : cnt_m + 1;
        exp_clear = 1'b0;
        exp_e     = 1'b0;
        edge_idx++;
        if (mode == M_IDLE || mode == M_HOLD) begin
            if (go) begin
                mode      = M_ACTIVE;
                n0        = edge_idx;
                exp_clear = 1'b1;
                exp_led   = 1'b0;
                exp_done  = 1'b0;
                exp_early = 1'b0;
                exp_ovf   = 1'b0;
            end
        end else begin
            r = edge_idx - n0;
            if (r >= 2) begin
                if (stop) begin
                    exp_done = 1'b1;
                    exp_led  = 1'b0;
                    if (r <= LED_EDGE) exp_early = 1'b1;
                    mode = M_HOLD;
                    $display("run from edge %0d: stopped at offset %0d early=%0d count=%0d",
                             n0, r, exp_early, cnt_m);
                end else if ((r - 1) % DIV == 0) begin
                    j = (r - 1) / DIV;
                    if (j == DLY) begin
                        exp_led = 1'b1;
                    end else if (j > DLY) begin
                        if (j - DLY <= 99) begin
                            exp_e = 1'b1;
                        end else begin
                            exp_ovf  = 1'b1;
                            exp_done = 1'b1;
                            exp_led  = 1'b0;
                            mode     = M_HOLD;
                            $display("run from edge %0d: saturated count=%0d", n0, cnt_m);
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_eq("clear", 32'(Clear), 32'(exp_clear));
        check_eq("e",     32'(E),     32'(exp_e));
        check_eq("led",   32'(LED),   32'(exp_led));
        check_eq("done",  32'(Done),  32'(exp_done));
        check_eq("early", 32'(Early), 32'(exp_early));
        check_eq("ovf",   32'(Ovf),   32'(exp_ovf));
        check_eq("count", 32'(cnt_reg), to_bcd(cnt_m));
    endtask

    // Called at a falling edge: drive inputs, take one rising edge, check at the next falling edge.
    task automatic cycle(input bit go, input bit stop);
        Go   = go;
        Stop = stop;
        @(posedge Clock);
        model_step(go, stop);
        @(negedge Clock);
        check_outputs();
    endtask

    initial begin
        int budget;
        model_reset();

        // Reset state, then Stop pulses while idle have no effect.
        #2;
        check_outputs();
        @(negedge Clock);
        check_outputs();
        Resetn = 1'b1;
        for (int i = 0; i < 6; i++) cycle(1'b0, i[0]);

        // Go pulse; Stop coincides with the 8th tick, so exactly 7 E pulses.
        cycle(1'b1, 1'b0);
        for (int r = 1; r < LED_EDGE + 8 * DIV; r++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check_eq("stop7_count", 32'(cnt_reg), 32'h07);
        check_eq("stop7_done",  32'(Done),    32'd1);
        check_eq("stop7_led",   32'(LED),     32'd0);

        // Early press at offset 6, inside the delay.
        cycle(1'b1, 1'b0);
        for (int r = 1; r < 6; r++) cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0);
        check_eq("early_flag",  32'(Early),   32'd1);
        check_eq("early_count", 32'(cnt_reg), 32'h00);

        // Run without Stop to saturation.
        cycle(1'b1, 1'b0);
        budget = 600;
        while (Done !== 1'b1 && budget > 0) begin
            cycle(1'b0, 1'b0);
            budget--;
        end
        check_eq("sat_done",  32'(Done),    32'd1);
        check_eq("sat_ovf",   32'(Ovf),     32'd1);
        check_eq("sat_count", 32'(cnt_reg), 32'h99);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        check_eq("sat_hold", 32'(cnt_reg), 32'h99);

        // Go from HOLD clears flags on entry, then reset drops mid-run.
        cycle(1'b1, 1'b0);
        check_eq("rego_clear", 32'(Clear), 32'd1);
        check_eq("rego_ovf",   32'(Ovf),   32'd0);
        check_eq("rego_done",  32'(Done),  32'd0);
        for (int r = 1; r < LED_EDGE + 10; r++) cycle(1'b0, 1'b0);
        #2 Resetn = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check_eq("async_led", 32'(LED), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
        $display("reset mid-run: block back in idle");

        // Random Go/Stop traffic.
        for (int i = 0; i < 4000; i++)
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 49) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reaction_timer_ctrl.md
# reaction_timer_ctrl

Sequencing controller for the two-digit BCD counter (Clear/E-driven, BCD1:BCD0 outputs) in the reaction-timer design. It clears the counter on a start request, waits a fixed prescaled delay, lights the stimulus LED, then pulses the counter enable at a prescaled rate until the user presses Stop. It flags an early press (Stop before the LED) and saturates at 99 instead of letting the counter wrap.

## Interface
Parameters:
- DIV, 500: Clock cycles per timer tick (one count). Legal range is DIV >= 2.
- DELAY_TICKS, 8: ticks from start until the LED lights. Legal range is 1..255.

Ports:
- Clock  in  1  system clock; all state changes on the rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Go  in  1  start request; level, sampled in IDLE and HOLD.
- Stop  in  1  reaction button; level, sampled in WAIT and RUN.
- BCD1  in  4  tens digit from the counter.
- BCD0  in  4  units digit from the counter.
- Clear  out  1  synchronous clear to the counter; one-cycle pulse.
- E  out  1  count enable to the counter; one-cycle pulse per tick.
- LED  out  1  stimulus light.
- Done  out  1  a result is held on the counter.
- Early  out  1  Stop was seen before the LED lit.
- Ovf  out  1  the count saturated at 99.

## Operation
- All outputs are registered.
- Reset (Resetn=0, asynchronous) forces:
  - state = IDLE;
  - Clear, E, LED, Done, Early and Ovf all = 0;
  - prescaler = 0 and delay counter = 0.
- States: IDLE, CLR, WAIT, RUN, HOLD.
- IDLE: Go=1 -> CLR and Clear<=1. Stop is ignored.
- CLR (exactly one cycle): the next state is always WAIT.
  - Clear<=0.
  - Prescaler, delay counter, Done, Early and Ovf are cleared.
  - Go and Stop are ignored.
- WAIT: the prescaler counts 0..DIV-1 and wraps. A "tick" is prescaler==DIV-1.
  - On each tick the delay counter increments.
  - Stop=1 has priority: go to HOLD with Early<=1 and Done<=1. LED stays 0.
  - On the DELAY_TICKS-th tick, go to RUN with LED<=1. The prescaler wraps to 0.
- RUN: the prescaler continues.
  - Stop=1 has priority over a same-cycle tick: go to HOLD with LED<=0 and Done<=1. E is not asserted.
  - On a tick with {BCD1,BCD0}==8'h99: go to HOLD with Ovf<=1, Done<=1 and LED<=0. E is not asserted, so there is no wrap to 00.
  - On any other tick: E<=1 for one cycle.
- HOLD: all flags are held and E=0.
  - Go=1 -> CLR with Clear<=1. Done, Early and Ovf clear on entry to CLR.
  - Stop is ignored.
- If Go is held high, a new run starts from HOLD every time one finishes.
- The BCD inputs are trusted. Digits above 9 are not checked. Only the exact value 8'h99 triggers saturation.

## Timing
- Go sampled at edge N in IDLE/HOLD:
  - Clear=1 between edges N and N+1;
  - WAIT is entered at N+1 with prescaler=0.
- LED rises at edge N+1+DELAY_TICKS*DIV.
- The k-th E pulse (k>=1) is high between edges N+1+(DELAY_TICKS+k)*DIV and that edge +1.
- The counter increments at the edge that ends the E pulse.
  - With DIV>=2, the BCD inputs are updated before the next tick compares them.
- Stop sampled at edge M in RUN: LED=0 and Done=1 after edge M. The counter value is frozen from then on.
- Stop sampled in WAIT: Early=1 and Done=1 one edge later. Clear has already zeroed the counter, so the count reads 00.
- Reset asserted mid-run: outputs drop immediately (asynchronously). After release the block waits in IDLE for Go.

## Test plan
Use DIV=4 and DELAY_TICKS=3, with a behavioural BCD counter connected to Clear and E.

- Reset, then release: all outputs = 0 and state IDLE. Stop pulses have no effect.
- Go pulse at edge N:
  - Clear high for one cycle;
  - LED rises at N+13;
  - the first E pulse appears at N+17;
  - E pulses repeat every 4 cycles.
- After 7 E pulses, assert Stop coincident with a tick edge:
  - no 8th E pulse;
  - LED=0 and Done=1;
  - counter reads 07.
- Stop at N+6 (during WAIT): Early=1, Done=1, LED never rises, E never pulses, counter reads 00.
- Run with no Stop:
  - after 99 E pulses the next tick gives Ovf=1, Done=1, LED=0, no E pulse;
  - the counter holds 99.
- From HOLD with Done=1, Ovf=1: Go -> Clear pulse, flags clear, and a new run starts. Separately, drop Resetn mid-RUN: all outputs are 0 asynchronously and the block returns to IDLE.
